rr_grant_encoder8: RTL and testbench
====================================

Name: rr_grant_encoder8

Overview:
- Round-robin arbiter for 8 requesters.
- Outputs the winner as a registered 3-bit binary index plus a valid flag.
- Sits directly upstream of the team's 3-to-8 one-hot decoder: grant_idx feeds the decoder's 3-bit input, and grant_valid gates the decoder's one-hot output at the consumer.
- Enforces bounded hold time and a break-before-make dead cycle between grants.

Parameters:
- HOLD_MAX, 15: max consecutive cycles a grant may be held before forced release; 0 = unlimited.
- CNT_W, 4: width of hold counter; must satisfy 2^CNT_W - 1 >= HOLD_MAX.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i.
- release_i  input  1  granted requester finished; sampled only in GRANT.
- grant_idx  output  3  binary index of current/last winner; feeds decoder input.
- grant_valid  output  1  grant_idx is an active grant.
- timeout  output  1  one-cycle pulse: grant was forcibly revoked by hold limit.

Behaviour:
- Async reset (rst_n=0), effective immediately regardless of clk:
  - State = IDLE; grant_idx = 3'd0; grant_valid = 0; timeout = 0.
  - Priority pointer ptr = 0; hold counter = 0.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, GRANT, GAP.
- Arbitration, evaluated in IDLE and GAP:
  - Winner = first set bit of req scanning ptr, ptr+1, ..., wrapping 7->0.
  - Winner is registered; next cycle: state = GRANT, grant_valid = 1, grant_idx = winner, counter = 1.
  - req = 0: remain IDLE (from GAP, go to IDLE).
  - Latency: req rising in IDLE -> grant_valid high on the next clock edge (1 cycle).
- GRANT:
  - grant_idx held stable.
  - Counter increments each cycle, saturating at HOLD_MAX.
- Exit conditions from GRANT, sampled each cycle:
  - (a) release_i = 1, or (b) req[grant_idx] = 0: next cycle GAP, timeout = 0.
  - (c) HOLD_MAX != 0, counter == HOLD_MAX, and neither (a) nor (b): next cycle GAP, timeout = 1 for exactly that cycle.
  - Simultaneous release and limit: release wins; no timeout pulse.
- On any exit from GRANT:
  - ptr <= grant_idx + 1, mod 8; 7 wraps to 0.
  - grant_valid <= 0.
  - Counter cleared.
- GAP:
  - Exactly one cycle with grant_valid = 0: the dead cycle guaranteeing no back-to-back one-hot overlap at the decoder.
  - Arbitration runs using the updated ptr.
- Release-to-new-grant: release sampled at edge N -> grant_valid 0 after N -> new grant valid after N+1.
- grant_idx retains the last winner while grant_valid = 0; it is not cleared except by reset.
- release_i ignored in IDLE and GAP.
- req changes during GRANT on non-granted bits have no effect until next arbitration.
- HOLD_MAX = 0: counter disabled; timeout never asserts.
- Reset mid-GRANT: grant_valid drops asynchronously; ptr returns to 0.

Test Plan:
- Reset, req=8'h00 for 5 cycles -> grant_valid=0, grant_idx=0, timeout=0 throughout.
- req=8'b1000_0001 held, release_i pulsed 1 cycle in each grant -> grant_idx sequence 0,7,0,7; one grant_valid=0 cycle between each grant.
- Grant idx 6 active, release, req=8'b0100_0100 -> next grant idx 2 (ptr wrapped 7->0 scan).
- HOLD_MAX=3, req=8'h10 held, no release -> grant_valid high 3 cycles, then timeout=1 with grant_valid=0 for 1 cycle, then regrant idx 4.
- HOLD_MAX=3, release_i=1 on the third GRANT cycle -> GAP entered; timeout stays 0.
- rst_n driven low mid-grant between clock edges -> grant_valid and grant_idx go to 0 immediately; after release, req=8'h0C grants idx 2 first.

Source files
------------

// File: rtl/rr_grant_encoder8_if.sv
// Request/grant bundle between the requesters and the round-robin grant encoder.
// The master side drives requests and release; the slave side is the arbiter.
interface rr_grant_encoder8_if;
    logic [7:0] req;
    logic       release_i;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        output release_i,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  release_i,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_encoder8.sv
// Round-robin arbiter for 8 requesters with a registered binary grant index.
// Feeds a 3-to-8 one-hot decoder, so every hand-over passes through one dead
// cycle (GAP) with grant_valid low to avoid one-hot overlap downstream.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; arbitrate on any request
// GRANT | grant_idx owns the resource; watch release, req drop, hold limit
// GAP   | one dead cycle after a grant ends; arbitrate with updated ptr
module rr_grant_encoder8 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_encoder8_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic             HOLD_EN  = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [15:0]      req_dbl;
    logic [7:0]       req_rot;
    logic [2:0]       win_off;
    logic [2:0]       winner;
    logic             any_req;

    // Winner search: rotate req so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> ptr_q;
        req_rot = req_dbl[7:0];
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
        winner  = ptr_q + win_off;
        any_req = |bus.req;
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    valid_d = 1'b1;
                    cnt_d   = HOLD_EN ? CNT_W'(1) : '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (bus.release_i || !bus.req[idx_q]) begin
                    // Release takes priority over the hold limit: no timeout pulse.
                    state_d = GAP;
                    ptr_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                end else if (HOLD_EN && (cnt_q == HOLD_LIM)) begin
                    state_d   = GAP;
                    ptr_d     = idx_q + 3'd1;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    if (HOLD_EN && (cnt_q != HOLD_LIM)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers; async active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder8.sv
// Bench for rr_grant_encoder8: three instances (hold limit 3, 15 and unlimited)
// share one stimulus stream; each is compared every cycle against a plain
// "who owns the resource and for how long" model, plus directed spot checks.
module tb_rr_grant_encoder8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_grant_encoder8_if bus_h3();
    rr_grant_encoder8_if bus_h15();
    rr_grant_encoder8_if bus_h0();

    rr_grant_encoder8 #(.HOLD_MAX(3), .CNT_W(2)) u_h3 (
        .clk(clk), .rst_n(rst_n), .bus(bus_h3)
    );
    rr_grant_encoder8 #(.HOLD_MAX(15), .CNT_W(4)) u_h15 (
        .clk(clk), .rst_n(rst_n), .bus(bus_h15)
    );
    rr_grant_encoder8 #(.HOLD_MAX(0), .CNT_W(4)) u_h0 (
        .clk(clk), .rst_n(rst_n), .bus(bus_h0)
    );

    int hm[3] = '{3, 15, 0};

    // Model: owner = requester currently holding the grant (-1 = nobody),
    // held = cycles it has been shown valid, last = last winner index.
    int m_owner[3];
    int m_ptr[3];
    int m_held[3];
    int m_last[3];
    bit m_pulse[3];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_held[k]  = 0;
            m_last[k]  = 0;
            m_pulse[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl);
        for (int k = 0; k < 3; k++) begin
            m_pulse[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                bit leave = 1'b0;
                if (rl || !r[m_owner[k]]) begin
                    leave = 1'b1;
                end else if (hm[k] != 0 && m_held[k] == hm[k]) begin
                    leave      = 1'b1;
                    m_pulse[k] = 1'b1;
                end else begin
                    m_held[k]++;
                end
                if (leave) begin
                    m_ptr[k]   = (m_owner[k] + 1) % 8;
                    m_owner[k] = -1;
                    m_held[k]  = 0;
                end
            end else if (r != 8'h00) begin
                for (int s = 0; s < 8; s++) begin
                    int c = (m_ptr[k] + s) % 8;
                    if (r[c] && m_owner[k] < 0) begin
                        m_owner[k] = c;
                        m_last[k]  = c;
                        m_held[k]  = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] o_idx[3];
        logic       o_v[3];
        logic       o_to[3];
        o_idx[0] = bus_h3.grant_idx;  o_v[0] = bus_h3.grant_valid;  o_to[0] = bus_h3.timeout;
        o_idx[1] = bus_h15.grant_idx; o_v[1] = bus_h15.grant_valid; o_to[1] = bus_h15.timeout;
        o_idx[2] = bus_h0.grant_idx;  o_v[2] = bus_h0.grant_valid;  o_to[2] = bus_h0.timeout;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s/h%0d/valid", tag, hm[k]), 32'(o_v[k]), 32'(m_owner[k] >= 0));
            chk($sformatf("%s/h%0d/idx", tag, hm[k]), 32'(o_idx[k]), 32'(m_last[k]));
            chk($sformatf("%s/h%0d/timeout", tag, hm[k]), 32'(o_to[k]), 32'(m_pulse[k]));
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic rl);
        bus_h3.req  = r; bus_h3.release_i  = rl;
        bus_h15.req = r; bus_h15.release_i = rl;
        bus_h0.req  = r; bus_h0.release_i  = rl;
    endtask

    // One clock: inputs applied before the edge, model advanced, outputs
    // sampled 1 ns after the edge.
    task automatic cycle(input logic [7:0] r, input logic rl, input string tag);
        drive(r, rl);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(r, rl);
        #1;
        check_outputs(tag);
    endtask

    int seq[4] = '{0, 7, 0, 7};
    int v_exp[5] = '{1, 1, 1, 0, 1};
    int t_exp[5] = '{0, 0, 0, 1, 0};

    initial begin
        logic [7:0] rq;
        logic       rl;

        model_reset();
        drive(8'h00, 1'b0);

        // Reset with no requests.
        cycle(8'h00, 1'b0, "in_reset");
        cycle(8'h00, 1'b0, "in_reset");
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0, "idle_noreq");

        // Two requesters, release once per grant: 0,7,0,7 with gaps.
        for (int i = 0; i < 4; i++) begin
            cycle(8'h81, 1'b0, "rr_grant");
            chk("rr_seq_idx", 32'(bus_h15.grant_idx), 32'(seq[i]));
            chk("rr_seq_valid", 32'(bus_h15.grant_valid), 32'd1);
            cycle(8'h81, 1'b1, "rr_release");
            chk("rr_gap_valid", 32'(bus_h3.grant_valid), 32'd0);
        end

        // Settle to IDLE (ptr=0), grant 6, release, scan wraps to idx 2.
        cycle(8'h00, 1'b0, "settle");
        cycle(8'h00, 1'b0, "settle");
        cycle(8'h40, 1'b0, "grant6");
        chk("grant6_idx", 32'(bus_h15.grant_idx), 32'd6);
        cycle(8'h44, 1'b1, "rel6");
        cycle(8'h44, 1'b0, "wrap_grant");
        chk("wrap_idx", 32'(bus_h15.grant_idx), 32'd2);
        chk("wrap_valid", 32'(bus_h15.grant_valid), 32'd1);

        // Hold limit 3: three valid cycles, timeout gap, regrant idx 4.
        cycle(8'h00, 1'b0, "drop");
        cycle(8'h00, 1'b0, "drop");
        for (int i = 0; i < 5; i++) begin
            cycle(8'h10, 1'b0, "hold");
            chk($sformatf("hold_valid_%0d", i), 32'(bus_h3.grant_valid), 32'(v_exp[i]));
            chk($sformatf("hold_timeout_%0d", i), 32'(bus_h3.timeout), 32'(t_exp[i]));
        end
        chk("hold_regrant_idx", 32'(bus_h3.grant_idx), 32'd4);

        // Release on third grant cycle coincides with the limit: no timeout.
        cycle(8'h10, 1'b0, "hold2");
        cycle(8'h10, 1'b0, "hold3");
        chk("lim_valid3", 32'(bus_h3.grant_valid), 32'd1);
        cycle(8'h10, 1'b1, "rel_at_lim");
        chk("rel_at_lim_valid", 32'(bus_h3.grant_valid), 32'd0);
        chk("rel_at_lim_timeout", 32'(bus_h3.timeout), 32'd0);

        // Move ptr to 3, grant idx 3, then reset asynchronously mid-grant.
        cycle(8'h04, 1'b0, "pre_rst");
        cycle(8'h04, 1'b1, "pre_rst");
        cycle(8'h08, 1'b0, "pre_rst");
        cycle(8'h08, 1'b0, "pre_rst");
        chk("pre_rst_idx", 32'(bus_h15.grant_idx), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(bus_h15.grant_valid), 32'd0);
        chk("async_rst_idx", 32'(bus_h15.grant_idx), 32'd0);
        check_outputs("async_rst");
        cycle(8'h0C, 1'b0, "held_rst");
        #3 rst_n = 1'b1;
        cycle(8'h0C, 1'b0, "post_rst");
        chk("post_rst_idx", 32'(bus_h15.grant_idx), 32'd2);

        // Random phase: busy traffic, then long holds to reach the limits.
        rq = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
            rl = ($urandom_range(0, 5) == 0);
            cycle(rq, rl, "rand_busy");
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) rq = 8'($urandom);
            rl = ($urandom_range(0, 39) == 0);
            cycle(rq, rl, "rand_long");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
